// File: rtl/alarm_pulse_driver.sv
// alarm_pulse_driver: turns 1-cycle trigger/stop/snooze pulses into a timed beep pattern
//
// Ports:
//   clk       system clock, all logic on posedge
//   rst       synchronous active-low reset
//   trigger   1-cycle pulse, start/restart the pattern
//   stop      1-cycle pulse, end the pattern now
//   snooze    1-cycle pulse, silence then restart (only with ALARM_SNOOZE_EN)
//   buzz      registered buzzer/LED drive
//   active    registered, high in ON/OFF
//   snoozing  registered, high in SNOOZE (tied 0 without ALARM_SNOOZE_EN)
//   done      registered 1-cycle pulse when a pattern ends
//
// Optional feature: define ALARM_SNOOZE_EN to build the SNOOZE state.
module alarm_pulse_driver #(
    parameter int TICK_DIV     = 50000,
    parameter int ON_TICKS     = 200,
    parameter int OFF_TICKS    = 300,
    parameter int BURSTS       = 10,
    parameter int SNOOZE_TICKS = 60000
) (
    input  logic clk,
    input  logic rst,
    input  logic trigger,
    input  logic stop,
    input  logic snooze,
    output logic buzz,
    output logic active,
    output logic snoozing,
    output logic done
);
`ifdef ALARM_SNOOZE_EN
    localparam int TMAX0 = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int TMAX  = (SNOOZE_TICKS > TMAX0) ? SNOOZE_TICKS : TMAX0;
`else
    localparam int TMAX  = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unused_snooze_ticks = SNOOZE_TICKS;
`endif
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int BW = (BURSTS > 1) ? $clog2(BURSTS) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [BW-1:0] B_LAST   = BW'((BURSTS > 0) ? BURSTS - 1 : 0);
`ifdef ALARM_SNOOZE_EN
    localparam logic [TW-1:0] SNZ_LAST = TW'(SNOOZE_TICKS - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        ON,
        OFF
`ifdef ALARM_SNOOZE_EN
        , SNOOZE
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [TW-1:0] tick_q, tick_d;
    logic [BW-1:0] burst_q, burst_d;
    logic          buzz_q, buzz_d;
    logic          active_q, active_d;
    logic          snoozing_q, snoozing_d;
    logic          done_q, done_d;
    logic          enter, wrap, expire;
    logic [TW-1:0] last_tick;

    always_comb begin
        state_d   = state_q;
        burst_d   = burst_q;
        done_d    = 1'b0;
        enter     = 1'b0;
        wrap      = presc_q == PRE_LAST;
`ifdef ALARM_SNOOZE_EN
        last_tick = (state_q == SNOOZE) ? SNZ_LAST : (state_q == ON) ? ON_LAST : OFF_LAST;
`else
        last_tick = (state_q == ON) ? ON_LAST : OFF_LAST;
`endif
        expire    = wrap && tick_q == last_tick;
        if (state_q == IDLE) begin
            // stop wins over a simultaneous trigger, so IDLE only leaves on a clean trigger
            if (trigger && !stop) begin
                state_d = ON;
                burst_d = '0;
                enter   = 1'b1;
            end
        end else if (stop) begin
            state_d = IDLE;
            burst_d = '0;
            done_d  = 1'b1;
            enter   = 1'b1;
        end else if (trigger) begin
            state_d = ON;
            burst_d = '0;
            enter   = 1'b1;
`ifdef ALARM_SNOOZE_EN
        end else if (snooze) begin
            // re-entering SNOOZE from SNOOZE restarts the silence timer
            state_d = SNOOZE;
            enter   = 1'b1;
`endif
        end else if (expire) begin
            enter = 1'b1;
            if (state_q == ON) begin
                state_d = OFF;
            end else if (state_q == OFF) begin
                if (BURSTS != 0 && burst_q == B_LAST) begin
                    state_d = IDLE;
                    burst_d = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ON;
                    // endless mode never needs the count, so hold it to avoid overflow
                    burst_d = (BURSTS == 0) ? burst_q : burst_q + 1'b1;
                end
            end else begin
                state_d = ON;
                burst_d = '0;
            end
        end
        presc_d    = (enter || state_d == IDLE || wrap) ? '0 : presc_q + 1'b1;
        tick_d     = (enter || state_d == IDLE) ? '0 : wrap ? tick_q + 1'b1 : tick_q;
        buzz_d     = state_d == ON;
        active_d   = state_d == ON || state_d == OFF;
`ifdef ALARM_SNOOZE_EN
        snoozing_d = state_d == SNOOZE;
`else
        snoozing_d = 1'b0;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            tick_q     <= '0;
            burst_q    <= '0;
            buzz_q     <= 1'b0;
            active_q   <= 1'b0;
            snoozing_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            tick_q     <= tick_d;
            burst_q    <= burst_d;
            buzz_q     <= buzz_d;
            active_q   <= active_d;
            snoozing_q <= snoozing_d;
            done_q     <= done_d;
        end
    end

`ifndef ALARM_SNOOZE_EN
    logic unused_snooze;
    assign unused_snooze = snooze ^ snoozing_q;
`endif

    assign buzz     = buzz_q;
    assign active   = active_q;
    assign done     = done_q;
`ifdef ALARM_SNOOZE_EN
    assign snoozing = snoozing_q;
`else
    assign snoozing = 1'b0;
`endif
endmodule

// File: tb/tb_alarm_pulse_driver.sv
// tb_alarm_pulse_driver: directed checks of the beep pattern with small timing parameters
module tb_alarm_pulse_driver;
    logic clk = 1'b0;
    logic rst, trigger, stop, snooze;
    logic buzz, active, snoozing, done;
    int   n_checks = 0;
    int   n_fail   = 0;

    alarm_pulse_driver #(
        .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1), .BURSTS(3), .SNOOZE_TICKS(5)
    ) dut (
        .clk(clk), .rst(rst), .trigger(trigger), .stop(stop), .snooze(snooze),
        .buzz(buzz), .active(active), .snoozing(snoozing), .done(done)
    );

    always #5 clk = ~clk;

    // {buzz, active, snoozing, done}
    function automatic logic [3:0] obs();
        return {buzz, active, snoozing, done};
    endfunction

    // expected outputs k cycles after a trigger into an idle driver: 3 x (8 on, 4 off), done at 37
    function automatic logic [3:0] exp_pat(int k);
        logic b, a;
        a = k >= 1 && k <= 36;
        b = a && ((k - 1) % 12) < 8;
        return {b, a, 1'b0, k == 37};
    endfunction

    task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; trigger = 1'b1; stop = 1'b0; snooze = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset_%0d", i), obs(), 4'b0000);
        end
        rst = 1'b1; trigger = 1'b0;
        tick();
        check("idle_after_reset", obs(), 4'b0000);

        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k <= 38; k++) begin
            check($sformatf("pattern_k%0d", k), obs(), exp_pat(k));
            if (k < 38) tick();
        end

        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        check("stop_pre_t5", obs(), 4'b1100);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_t6", obs(), 4'b0001);
        tick();
        check("stop_t7", obs(), 4'b0000);

        stop = 1'b1; snooze = 1'b1; tick(); stop = 1'b0; snooze = 1'b0;
        check("stop_snooze_idle", obs(), 4'b0000);

        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 10; k++) tick();
        check("retrig_pre_t10", obs(), 4'b0100);
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 11; k <= 48; k++) begin
            check($sformatf("retrig_k%0d", k), obs(), exp_pat(k - 10));
            if (k < 48) tick();
        end

        trigger = 1'b1; stop = 1'b1; tick(); trigger = 1'b0; stop = 1'b0;
        check("trig_stop_idle_a", obs(), 4'b0000);
        tick();
        check("trig_stop_idle_b", obs(), 4'b0000);

        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 20; k++) tick();
        check("rst_pre_t20", obs(), 4'b1100);
        rst = 1'b0; tick(); rst = 1'b1;
        check("rst_mid_t21", obs(), 4'b0000);
        tick();
        check("rst_mid_t22", obs(), 4'b0000);

`ifdef ALARM_SNOOZE_EN
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 3; k++) tick();
        snooze = 1'b1; tick(); snooze = 1'b0;
        for (int k = 4; k <= 23; k++) begin
            check($sformatf("snooze_k%0d", k), obs(), 4'b0010);
            tick();
        end
        check("snooze_wake_t24", obs(), 4'b1100);
        stop = 1'b1; tick(); stop = 1'b0;
        check("snooze_wake_stop", obs(), 4'b0001);
        tick();

        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 3; k++) tick();
        snooze = 1'b1; tick(); snooze = 1'b0;
        for (int k = 4; k < 10; k++) tick();
        check("snooze_pre_stop", obs(), 4'b0010);
        stop = 1'b1; tick(); stop = 1'b0;
        check("snooze_stop_t11", obs(), 4'b0001);
        tick();
        check("snooze_stop_t12", obs(), 4'b0000);
`else
        trigger = 1'b1; tick(); trigger = 1'b0;
        for (int k = 1; k < 3; k++) tick();
        snooze = 1'b1; tick(); snooze = 1'b0;
        for (int k = 4; k <= 10; k++) begin
            check($sformatf("snooze_ignored_k%0d", k), obs(), exp_pat(k));
            tick();
        end
        stop = 1'b1; tick(); stop = 1'b0;
        check("snooze_ignored_stop", obs(), 4'b0001);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
